// File: rtl/rggen_command_arbiter_pkg.sv
// rggen_arbiter_pkg: shared types, status codes and index helper for the command arbiter.
package rggen_arbiter_pkg;
    typedef enum logic {
        IDLE,
        COMMAND
    } rggen_arbiter_state_e;

    localparam logic [1:0] RGGEN_OKAY   = 2'b00;
    localparam logic [1:0] RGGEN_SLVERR = 2'b01;

    function automatic int rotate_index(input int base, input int offset, input int width);
        return (base + offset) % width;
    endfunction
endpackage

// File: rtl/rggen_command_arbiter_if.sv
// rggen_command_arbiter_if: host-side requests plus the shared register-block command/response port.
interface rggen_command_arbiter_if #(
    parameter int HOSTS         = 2,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic [HOSTS-1:0]                    i_host_command_valid;
    logic [HOSTS-1:0]                    i_host_read;
    logic [HOSTS-1:0][ADDRESS_WIDTH-1:0] i_host_address;
    logic [HOSTS-1:0][DATA_WIDTH-1:0]    i_host_write_data;
    logic [HOSTS-1:0]                    o_host_response_ready;
    logic [DATA_WIDTH-1:0]               o_host_read_data;
    logic [1:0]                          o_host_status;
    logic                                o_command_valid;
    logic                                o_read;
    logic [ADDRESS_WIDTH-1:0]            o_address;
    logic [DATA_WIDTH-1:0]               o_write_data;
    logic                                i_response_ready;
    logic [DATA_WIDTH-1:0]               i_read_data;
    logic [1:0]                          i_status;

    modport slave (
        input  i_host_command_valid, i_host_read, i_host_address, i_host_write_data,
        input  i_response_ready, i_read_data, i_status,
        output o_host_response_ready, o_host_read_data, o_host_status,
        output o_command_valid, o_read, o_address, o_write_data
    );

    modport master (
        output i_host_command_valid, i_host_read, i_host_address, i_host_write_data,
        output i_response_ready, i_read_data, i_status,
        input  o_host_response_ready, o_host_read_data, o_host_status,
        input  o_command_valid, o_read, o_address, o_write_data
    );
endinterface

// File: rtl/rggen_round_robin_select.sv
// rggen_round_robin_select: one-hot rotating-priority pick, search starts just after i_last_grant.
module rggen_round_robin_select
    import rggen_arbiter_pkg::*;
#(
    parameter  int WIDTH = 2,
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_request,
    input  logic [IW-1:0]    i_last_grant,
    output logic [WIDTH-1:0] o_grant,
    output logic [IW-1:0]    o_grant_index
);
    logic [IW-1:0] w_idx;

    // Walk from farthest to nearest so the closest requester after last_grant wins.
    always_comb begin
        o_grant       = '0;
        o_grant_index = '0;
        w_idx         = '0;
        for (int i = WIDTH; i >= 1; i--) begin
            w_idx = IW'(rotate_index(int'(i_last_grant), i, WIDTH));
            if (i_request[w_idx]) begin
                o_grant       = WIDTH'(1) << w_idx;
                o_grant_index = w_idx;
            end
        end
    end
endmodule

// File: rtl/rggen_command_arbiter.sv
// rggen_command_arbiter: round-robin share of one register-block port between HOSTS bridges,
// with a timeout that answers SLVERR when the register block stays silent.
module rggen_command_arbiter
    import rggen_arbiter_pkg::*;
#(
    parameter int HOSTS          = 2,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                     clk,
    input logic                     rst,
    rggen_command_arbiter_if.slave  io_bus
);
    localparam int LW = $clog2(HOSTS);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    rggen_arbiter_state_e     r_state;
    rggen_arbiter_state_e     w_next_state;
    logic [HOSTS-1:0]         r_grant;
    logic [LW-1:0]            r_last_grant;
    logic                     r_read;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0]    r_write_data;
    logic [TW-1:0]            r_timeout_count;
    logic [HOSTS-1:0]         w_grant;
    logic [LW-1:0]            w_grant_index;
    logic                     w_start;
    logic                     w_response;
    logic                     w_timeout;
    logic                     w_done;

    rggen_round_robin_select #(
        .WIDTH (HOSTS)
    ) u_select (
        .i_request     (io_bus.i_host_command_valid),
        .i_last_grant  (r_last_grant),
        .o_grant       (w_grant),
        .o_grant_index (w_grant_index)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // A real response on the timeout cycle takes precedence over the abort.
    always_comb begin
        w_start      = (r_state == IDLE) && |io_bus.i_host_command_valid;
        w_response   = (r_state == COMMAND) && io_bus.i_response_ready;
        w_timeout    = (TIMEOUT_CYCLES != 0) && (r_state == COMMAND) &&
                       !io_bus.i_response_ready && (r_timeout_count == TLAST);
        w_done       = w_response || w_timeout;
        w_next_state = w_start ? COMMAND : w_done ? IDLE : r_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant         <= '0;
            r_last_grant    <= LW'(HOSTS - 1);
            r_read          <= 1'b0;
            r_address       <= '0;
            r_write_data    <= '0;
            r_timeout_count <= '0;
        end else begin
            if (w_start) begin
                r_grant      <= w_grant;
                r_last_grant <= w_grant_index;
                r_read       <= io_bus.i_host_read[w_grant_index];
                r_address    <= io_bus.i_host_address[w_grant_index];
                r_write_data <= io_bus.i_host_write_data[w_grant_index];
            end
            if (w_start)
                r_timeout_count <= '0;
            else if ((r_state == COMMAND) && !io_bus.i_response_ready)
                r_timeout_count <= r_timeout_count + TW'(1);
        end
    end

    assign io_bus.o_command_valid       = (r_state == COMMAND);
    assign io_bus.o_read                = r_read;
    assign io_bus.o_address             = r_address;
    assign io_bus.o_write_data          = r_write_data;
    assign io_bus.o_host_response_ready = w_done ? r_grant : '0;
    assign io_bus.o_host_read_data      = w_response ? io_bus.i_read_data : '0;
    assign io_bus.o_host_status         = w_response ? io_bus.i_status :
                                          w_timeout  ? RGGEN_SLVERR : RGGEN_OKAY;
endmodule

// File: doc/rggen_command_arbiter.md
# rggen_command_arbiter

Round-robin arbiter that shares one register-block command/response port between `HOSTS` independent host-side bridges. It grants one host at a time and registers that host's command. It drives the shared command into the response multiplexer and routes the one-cycle response back to the granted host. A timeout counter aborts transactions the register block never answers.

## Interface
Parameters:
- `HOSTS`, 2, number of requesting hosts (≥2)
- `ADDRESS_WIDTH`, 16, byte address width
- `DATA_WIDTH`, 32, data width
- `TIMEOUT_CYCLES`, 64, cycles in COMMAND before abort; 0 disables timeout

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `i_host_command_valid`  in  [HOSTS]  per-host request, held until its response_ready
- `i_host_read`  in  [HOSTS]  1 = read, 0 = write
- `i_host_address`  in  [HOSTS][ADDRESS_WIDTH]  per-host address
- `i_host_write_data`  in  [HOSTS][DATA_WIDTH]  per-host write data
- `o_host_response_ready`  out  [HOSTS]  one-hot response strobe, granted host only
- `o_host_read_data`  out  DATA_WIDTH  response read data, shared by all hosts
- `o_host_status`  out  2  response status, shared by all hosts
- `o_command_valid`  out  1  command to register block
- `o_read`  out  1  registered read flag
- `o_address`  out  ADDRESS_WIDTH  registered address
- `o_write_data`  out  DATA_WIDTH  registered write data
- `i_response_ready`  in  1  register-block response strobe
- `i_read_data`  in  DATA_WIDTH  register-block read data
- `i_status`  in  2  register-block status

## Operation
- States: IDLE, COMMAND. Reset → IDLE.
- IDLE: if any `i_host_command_valid` is set, pick a winner by rotating priority. The search starts at `last_grant+1` mod `HOSTS`.
  - Register `grant` (one-hot) and `last_grant`.
  - Capture the winner's read, address and write_data into the `o_*` registers.
  - Go to COMMAND.
  - No request: stay in IDLE.
- COMMAND: `o_command_valid`=1, and the command registers are stable.
  - `i_response_ready`=1 → drive `o_host_response_ready`=`grant` for that cycle, pass `i_read_data`/`i_status` through to the host outputs, go to IDLE.
  - Otherwise increment `timeout_count`.
  - Timeout: `TIMEOUT_CYCLES`≠0 and `timeout_count`==`TIMEOUT_CYCLES`-1 with no ready. Drive `o_host_response_ready`=`grant`, `o_host_status`=2'b01 (SLVERR), `o_host_read_data`=0, go to IDLE.
- Response and timeout on the same cycle: the real response wins.
- Response outputs are 0 on every cycle with no response strobe.
- A host dropping valid after grant is a protocol violation. The captured command completes regardless.
- `timeout_count` clears on entry to COMMAND. Its width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1 bit.
- Reset values:
  - all `o_*` outputs 0
  - `grant`=0
  - `last_grant`=`HOSTS`-1, so host 0 has top priority after reset
- Reset mid-transaction: immediate return to IDLE. `o_command_valid` drops asynchronously. No response is issued to the host.

## Timing
- Request sampled in IDLE at cycle N → `o_command_valid` high from N+1.
- The response multiplexer answers at N+2. The host sees `o_host_response_ready` at N+2, combinational from `i_response_ready`.
- IDLE at N+3; the next grant can be taken at N+3. Back-to-back throughput is one transaction per 3 cycles.
- `o_command_valid` is low in the cycle after `i_response_ready`, so the multiplexer never sees a second command.
- Timeout: response to the host at N+`TIMEOUT_CYCLES`.
- A host may re-raise valid the cycle after its response. It competes at lowest priority.

## Structure
- Package `rggen_arbiter_pkg`:
  - state enum `rggen_arbiter_state_e` {IDLE, COMMAND}
  - status constants `RGGEN_OKAY`=2'b00, `RGGEN_SLVERR`=2'b01
- Sub-module `rggen_round_robin_select`: combinational rotating-priority one-hot select.
  - Parameter `WIDTH`.
  - Inputs: request vector, last_grant.
  - Output: next grant.
- Top level holds the FSM, command registers, timeout counter and response routing.

## Test plan
- Single host 0 reads 0x0010, register returns 0xDEADBEEF/2'b00 two cycles after request → `o_host_response_ready`=2'b01 at N+2, `o_host_read_data`=0xDEADBEEF, status 0.
- Hosts 0 and 1 request continuously after reset → grants alternate 0,1,0,1. Each transaction takes 3 cycles. `o_command_valid` is low one cycle between transactions.
- Host 1 writes 0x12345678 to 0x0004 while host 0 raises valid mid-transaction → `o_address`/`o_write_data` stay 0x0004/0x12345678 until the response. Host 0 is served next.
- `TIMEOUT_CYCLES`=4, `i_response_ready` tied low → response to the host at N+4 with status 2'b01 and data 0. The FSM returns to IDLE.
- `TIMEOUT_CYCLES`=4, `i_response_ready` arrives exactly on the timeout cycle with status 2'b00 and data 0xA5A5A5A5 → the real response is delivered with status 0.
- Assert `rst` during COMMAND → all outputs are 0 immediately with no host response. After release, host 0 wins a simultaneous 0/1 request.
